// File: rtl/dec_sample_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : dec_sample_serializer_if
// Brief    : Sample-in / serial-out bundle of the decimated-sample serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface dec_sample_serializer_if #(
    parameter int DATA_BITS  = 16,
    parameter int FIFO_DEPTH = 4
);
    logic                          in_valid;
    logic [DATA_BITS-1:0]          in_data;
    logic                          enable;
    logic                          clr_ovf;
    logic                          sclk;
    logic                          sdata;
    logic                          sframe;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          overflow;
    logic                          busy;

    modport master (
        output in_valid, in_data, enable, clr_ovf,
        input  sclk, sdata, sframe, fifo_level, overflow, busy
    );

    modport slave (
        input  in_valid, in_data, enable, clr_ovf,
        output sclk, sdata, sframe, fifo_level, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/dec_sample_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dec_sample_serializer
// Brief    : Buffers decimated samples in a FIFO and shifts them out MSB-first
//            on a sclk/sdata/sframe link, flagging dropped samples.
// Revision : 1.0 - initial release
// ============================================================================
module dec_sample_serializer #(
    parameter int DATA_BITS  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV        = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    dec_sample_serializer_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int DIV_W = $clog2(DIV);

    localparam logic [LVL_W-1:0] c_full_lvl = LVL_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] c_half_m1  = DIV_W'(DIV / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 sdata_q, sdata_d;
    logic                 sframe_q, sframe_d;
    logic                 busy_q, busy_d;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [DATA_BITS-1:0] w_head;

    assign w_full  = (level_q == c_full_lvl);
    assign w_empty = (level_q == '0);
    assign w_pop   = (state_q == S_IDLE) && bus.enable && !w_empty;
    // A pop on the same edge frees the slot, so a write while full still lands.
    assign w_push  = bus.in_valid && (!w_full || w_pop);
    assign w_drop  = bus.in_valid && w_full && !w_pop;
    assign w_head  = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= bus.in_data;
        end
    end

    always_comb begin
        wr_ptr_d   = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d    = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            level_d = level_q - LVL_W'(1);
        end
        overflow_d = overflow_q;
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        sframe_d  = sframe_q;

        unique case (state_q)
            S_IDLE: begin
                sclk_d   = 1'b0;
                sdata_d  = 1'b0;
                sframe_d = 1'b0;
                if (w_pop) begin
                    shreg_d   = w_head;
                    sdata_d   = w_head[DATA_BITS-1];
                    sframe_d  = 1'b1;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_cnt_q == c_div_last) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b0;
                    if (bit_cnt_q == c_bit_last) begin
                        sframe_d = 1'b0;
                        sdata_d  = 1'b0;
                        state_d  = S_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shreg_d   = {shreg_q[DATA_BITS-2:0], 1'b0};
                        sdata_d   = shreg_q[DATA_BITS-2];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                    // sclk rises once the next cycle enters the second half-bit.
                    sclk_d    = (div_cnt_q >= c_half_m1);
                end
            end
            S_GAP: begin
                if (div_cnt_q == c_div_last) begin
                    div_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            sframe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            sframe_q   <= sframe_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sclk       = sclk_q;
    assign bus.sdata      = sdata_q;
    assign bus.sframe     = sframe_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_sample_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_sample_serializer
// Brief    : Directed stimulus with a queue scoreboard and serial-link monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_sample_serializer;

    logic clk;
    logic rst_n;

    dec_sample_serializer_if #(.DATA_BITS(16), .FIFO_DEPTH(4)) bus ();

    dec_sample_serializer #(
        .DATA_BITS (16),
        .FIFO_DEPTH(4),
        .DIV       (4)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] exp_q [$];
    int          rise_q [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Serial monitor: samples sdata on each sclk rise within a frame.
    logic        prev_sclk = 1'b0;
    logic        prev_sframe = 1'b0;
    logic [15:0] mon_word = '0;
    int          mon_bits = 0;
    int          mon_len  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sclk   = 1'b0;
            prev_sframe = 1'b0;
            mon_bits    = 0;
            mon_len     = 0;
        end else begin
            if (bus.sframe) begin
                if (!prev_sframe) begin
                    mon_bits = 0;
                    mon_len  = 0;
                    mon_word = '0;
                    rise_q.push_back(cyc);
                end
                mon_len++;
                if (bus.sclk && !prev_sclk) begin
                    mon_word = {mon_word[14:0], bus.sdata};
                    mon_bits++;
                end
            end else if (prev_sframe) begin
                chk("frame_bits", mon_bits, 16);
                chk("frame_len", mon_len, 64);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    chk("frame_data", mon_word, exp_q.pop_front());
                end
            end
            prev_sclk   = bus.sclk;
            prev_sframe = bus.sframe;
        end
    end

    task automatic put(input logic [15:0] d, input bit expect_out);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        if (expect_out) exp_q.push_back(d);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus.busy || bus.sframe || bus.fifo_level != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 2000), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.enable   = 1'b0;
        bus.clr_ovf  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_sdata", bus.sdata, 0);
        chk("rst_sframe", bus.sframe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single sample with latency and word-length timing.
        bus.enable = 1'b1;
        @(negedge clk); put(16'hA5C3, 1);
        @(negedge clk); bus.in_valid = 1'b0;
        chk("single_sframe_pre", bus.sframe, 0);
        chk("single_level_pre", bus.fifo_level, 1);
        @(negedge clk);
        chk("single_sframe_rise", bus.sframe, 1);
        chk("single_level_post", bus.fifo_level, 0);
        chk("single_busy", bus.busy, 1);
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("single_busy_len", n, 68);
        wait_idle("single_idle");

        // Back-to-back words.
        rise_q.delete();
        @(negedge clk); put(16'h0001, 1);
        @(negedge clk); chk("b2b_level1", bus.fifo_level, 1); put(16'h8000, 1);
        @(negedge clk); chk("b2b_level2", bus.fifo_level, 1); put(16'hFFFF, 1);
        @(negedge clk); bus.in_valid = 1'b0; chk("b2b_level3", bus.fifo_level, 2);
        wait_idle("b2b_idle");
        chk("b2b_frames", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            chk("b2b_period1", rise_q[1] - rise_q[0], 69);
            chk("b2b_period2", rise_q[2] - rise_q[1], 69);
        end

        // Overflow with enable low.
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); put(16'h0010 + 16'(i), (i < 4));
        end
        @(negedge clk); bus.in_valid = 1'b0;
        chk("ovf_level", bus.fifo_level, 4);
        chk("ovf_flag", bus.overflow, 1);
        bus.enable = 1'b1;
        wait_idle("ovf_idle");
        chk("ovf_sticky", bus.overflow, 1);
        bus.clr_ovf = 1'b1;
        @(negedge clk); bus.clr_ovf = 1'b0;
        chk("ovf_cleared", bus.overflow, 0);

        // Write while full on the same edge as the IDLE pop.
        bus.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); put(16'h0100 + 16'(i), 1);
        end
        @(negedge clk); bus.in_valid = 1'b0;
        chk("full_level_pre", bus.fifo_level, 4);
        @(negedge clk); bus.enable = 1'b1; put(16'h0104, 1);
        @(negedge clk); bus.in_valid = 1'b0;
        chk("full_level_post", bus.fifo_level, 4);
        chk("full_ovf", bus.overflow, 0);
        wait_idle("full_idle");

        // enable dropped mid-word.
        @(negedge clk); put(16'h1234, 1);
        @(negedge clk); put(16'h5678, 1);
        @(negedge clk); bus.in_valid = 1'b0;
        repeat (21) @(negedge clk);
        bus.enable = 1'b0;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("en_word_done", (n < 200), 1);
        repeat (10) @(negedge clk);
        chk("en_sframe_low", bus.sframe, 0);
        chk("en_level", bus.fifo_level, 1);
        chk("en_pending", exp_q.size(), 1);
        bus.enable = 1'b1;
        wait_idle("en_idle");

        // Asynchronous reset mid-word.
        @(negedge clk); put(16'hBEEF, 1);
        @(negedge clk); put(16'h1111, 1);
        @(negedge clk); bus.in_valid = 1'b0;
        repeat (33) @(negedge clk);
        chk("arst_pre_sframe", bus.sframe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sclk", bus.sclk, 0);
        chk("arst_sdata", bus.sdata, 0);
        chk("arst_sframe", bus.sframe, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_level", bus.fifo_level, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); put(16'h3C5A, 1);
        @(negedge clk); bus.in_valid = 1'b0;
        wait_idle("arst_idle");

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dec_sample_serializer.md
Name: dec_sample_serializer

Overview:
- Downstream stage of the decimation filter. Captures each 16-bit decimated sample on a valid strobe and buffers it in a small FIFO.
- Shifts samples out MSB-first on a three-wire synchronous serial link (sclk, sdata, sframe) for an off-chip logger or MCU.
- Decouples the filter's output rate from the serial link rate and flags dropped samples.

Parameters:
- DATA_BITS, 16, width of one sample and of one serial word
- FIFO_DEPTH, 4, sample buffer entries; must be a power of two, at least 2
- DIV, 4, clk cycles per serial bit; must be even, at least 2

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle strobe: in_data holds a new decimated sample
- in_data  in  DATA_BITS  decimated sample
- enable  in  1  permits starting new serial words
- clr_ovf  in  1  synchronous clear of overflow
- sclk  out  1  serial bit clock
- sdata  out  1  serial data, MSB first
- sframe  out  1  high for the whole duration of a word
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, range 0..FIFO_DEPTH
- overflow  out  1  sticky flag: a sample was dropped
- busy  out  1  high while the state machine is not in IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - sclk, sdata, sframe, overflow and busy are 0; fifo_level is 0.
  - FIFO pointers, shift register, bit counter and divider counter are cleared; state is IDLE.
  - Asserting reset mid-word aborts the word immediately with no partial completion.
- All outputs are registered.
- FIFO write:
  - When in_valid=1 and the FIFO is not full, in_data is written on that edge.
  - When in_valid=1 and the FIFO is full, the sample is dropped and overflow is set to 1 on that edge.
  - When a pop and a write happen on the same edge while full, the write is accepted. fifo_level is unchanged and overflow is not set.
- overflow: clr_ovf=1 clears it. If clr_ovf and a new drop occur on the same edge, the drop wins and overflow stays 1.
- State machine: IDLE, SHIFT, GAP.
  - IDLE: if enable=1 and fifo_level>0, pop the head into the shift register. Set sframe=1, sdata=word MSB, sclk=0, bit_cnt=0, div_cnt=0, and go to SHIFT. Otherwise hold sframe=0, sclk=0, sdata=0.
  - SHIFT: each bit lasts DIV cycles. sclk=0 for the first DIV/2 cycles and 1 for the last DIV/2 cycles. sdata changes only when sclk goes 0, so it is stable across the sclk rising edge.
  - SHIFT, end of a bit: at the end of the last cycle of bit i, if i<DATA_BITS-1, advance to bit i+1. If i=DATA_BITS-1, drive sframe=0, sclk=0, sdata=0 and go to GAP.
  - GAP: lasts exactly DIV cycles, then returns to IDLE. A pending word therefore reloads on the following edge.
- Timing at defaults:
  - Word period is (DATA_BITS+1)*DIV+1 = 69 clk cycles when the FIFO stays non-empty.
  - A sample written on edge k into an empty FIFO with the machine in IDLE and enable=1 drives sframe=1 after edge k+1, giving 1-cycle latency.
- enable deasserted mid-word: the current word completes, including GAP. No new word starts until enable=1. The FIFO continues to accept writes.
- fifo_level counts with no wrap error. Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full is fifo_level==FIFO_DEPTH; empty is fifo_level==0.
- busy is 1 in SHIFT and GAP.

Test Plan:
- Reset then single sample: in_valid with in_data=0xA5C3 and enable=1. Required response:
  - sframe rises 1 cycle later and stays high 64 cycles.
  - sdata sampled on sclk rising edges reads 1010 0101 1100 0011.
  - sframe then stays low 4 cycles; busy falls after 68 cycles.
- Back-to-back: write 0x0001, 0x8000, 0xFFFF in consecutive cycles. Required response:
  - Three frames with sframe rising 69 cycles apart, data exact.
  - fifo_level sequence after writes is 1, 1, 2 (first popped immediately), then decrements per load.
- Overflow: enable=0, write 5 samples 0x0010..0x0014. Required response:
  - fifo_level=4, overflow=1.
  - Set enable=1: output 0x0010..0x0013 only.
  - Pulse clr_ovf and overflow returns to 0.
- Full write with simultaneous pop: FIFO full with enable=1. Assert in_valid on the same edge the IDLE load pops. Required response: fifo_level stays 4, overflow stays 0, and the new sample is transmitted fifth.
- enable dropped mid-word: deassert enable at bit 5 of 0x1234 with 0x5678 queued. Required response: 0x1234 completes, then sframe stays 0 and fifo_level=1. Reassert enable and 0x5678 is sent.
- Async reset mid-word: pull rst_n low at bit 8. Required response: sclk, sdata, sframe, busy and fifo_level go to 0 without a clock edge. After release, the first new sample is sent cleanly.
